instr_fetch_stage: RTL

// - Fetch stage of the RV32 core; sits directly upstream of Control_Unit.
// - Owns the PC, issues word requests to instruction memory and registers the returned instruction.
// - if_opcode (= if_instr[6:0]) drives Control_Unit.OpCode.
// - Handles downstream stall via a one-entry skid buffer, and branch redirect with in-flight discard.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 62 ++++++
 rtl/instr_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and its neighbours.
//   - Major opcode constants seen by Control_Unit
//   - fetch_state_t: fetch FSM encoding
//   - Ilen / PcStep: instruction width and sequential PC increment
package riscv_pkg;

  localparam int unsigned Ilen   = 32;
  localparam int unsigned PcStep = 4;

  localparam logic [6:0] OpcRType  = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFull,
    StDrain
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer. Catches a fetch response that arrives
// while the output register is occupied and stalled.
//   clk, rst_n        clock, async active-low reset
//   load_i            capture pc_i/instr_i, mark full
//   unload_i          entry consumed, mark empty
//   flush_i           discard entry (wins over load/unload)
//   pc_i, instr_i     entry to capture
//   full_o            entry valid
//   pc_o, instr_o     stored entry
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [Ilen-1:0] instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [Ilen-1:0] instr_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [Ilen-1:0] instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// RV32 fetch stage: owns the PC, requests words from instruction memory and
// registers the returned instruction for Control_Unit.
//   clk, rst_n                clock, async active-low reset
//   imem_req/imem_addr        request, held with stable address until imem_ready
//   imem_ready/imem_rdata     response strobe and instruction word
//   stall                     downstream cannot accept; if_* held
//   redirect/redirect_pc      taken branch: flush and refetch from target
//   if_valid/if_pc/if_instr   registered instruction and its PC
//   if_opcode                 if_instr[6:0] for Control_Unit.OpCode
module instr_fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [Ilen-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [Ilen-1:0] if_instr,
  output logic [6:0]      if_opcode
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [Ilen-1:0] out_instr_q, out_instr_d;

  logic            skid_load, skid_unload, skid_flush;
  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [Ilen-1:0] skid_instr;

  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_inc;
  logic            slot_free;
  logic            unused_redir_lsb;
  logic            unused_skid_full;

  // Fetches are word aligned; target low bits are ignored.
  assign redir_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  // Wraps modulo 2^XLEN by construction.
  assign pc_inc           = pc_q + XLEN'(PcStep);
  // Output register can take new data if empty or being consumed this cycle.
  assign slot_free        = !out_valid_q || !stall;
  // FULL state already implies an occupied skid entry.
  assign unused_skid_full = skid_full;

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .pc_i     (pc_q),
    .instr_i  (imem_rdata),
    .full_o   (skid_full),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (redirect) begin
          // An outstanding request cannot be withdrawn; wait it out in DRAIN.
          state_d = imem_ready ? StFetch : StDrain;
        end else if (imem_ready && !slot_free) begin
          state_d = StFull;
        end
      end
      StFull:  if (redirect || !stall) state_d = StFetch;
      StDrain: if (imem_ready) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: pc, pending redirect target, output register, skid control
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect) begin
      out_valid_d = 1'b0;
      skid_flush  = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (redirect) pc_d = redir_tgt;
      end
      StFetch: begin
        if (redirect) begin
          if (imem_ready) pc_d = redir_tgt;
          else            pend_d = redir_tgt;
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata;
          end else begin
            skid_load = 1'b1;
          end
        end else if (!stall) begin
          out_valid_d = 1'b0;
        end
      end
      StFull: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end else if (!stall) begin
          out_valid_d = 1'b1;
          out_pc_d    = skid_pc;
          out_instr_d = skid_instr;
          skid_unload = 1'b1;
        end
      end
      StDrain: begin
        // Latest redirect wins, including one arriving with the drained response.
        if (redirect) pend_d = redir_tgt;
        if (imem_ready) pc_d = redirect ? redir_tgt : pend_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // Outputs
  always_comb begin
    imem_req  = (state_q == StFetch) || (state_q == StDrain);
    imem_addr = pc_q;
    if_valid  = out_valid_q;
    if_pc     = out_pc_q;
    if_instr  = out_instr_q;
    if_opcode = out_instr_q[6:0];
  end

endmodule
